// File: rtl/alu_result_stage.sv
// alu_result_stage: registered 2-entry elastic buffer sitting directly behind
// the ALU. Each accepted result {opcode, y, N, Z, C, V} is queued in strict
// order for a possibly stalling consumer. The stage also keeps the
// architectural flags register, a sticky overflow bit and the carry-feedback
// bit that drives the ALU cin for chained multi-word arithmetic.
//
// Optional feature: define ALU_RESULT_STAGE_PERF_EN to add the xfer_cnt and
// stall_cnt performance counters. Both are cleared by sticky_clr.
module alu_result_stage #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_opcode,
  input  logic [N-1:0] in_y,
  input  logic         in_cout,
  input  logic         in_overflow,
  input  logic         in_negative,
  input  logic         in_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_opcode,
  output logic [N-1:0] out_y,
  output logic [3:0]   out_flags,
  output logic [3:0]   flags_q,
  output logic         carry_fb,
  output logic         sticky_ovf,
  input  logic         sticky_clr
`ifdef ALU_RESULT_STAGE_PERF_EN
  ,
  output logic [15:0]  xfer_cnt,
  output logic [15:0]  stall_cnt
`endif
);

  typedef struct packed {
    logic [3:0]   opcode;
    logic [N-1:0] y;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
  } entry_t;

  entry_t     slot [2];
  logic [1:0] count;
  logic       hd;
  logic       tail;
  logic       push;
  logic       pop;
  logic       rd_sel;
  entry_t     head_e;
  entry_t     in_e;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign tail      = hd ^ (count == 2'd1);

  assign in_e = '{opcode: in_opcode, y: in_y, n: in_negative, z: in_zero,
                  c: in_cout, v: in_overflow};

  // Every pop toggles hd, so while empty the most recently popped entry sits
  // in the slot just behind hd. Pointing the output there keeps out_* showing
  // the last popped entry, and a push into an empty buffer writes slot[hd],
  // so that entry is not overwritten.
  assign rd_sel     = out_valid ? hd : ~hd;
  assign head_e     = slot[rd_sel];
  assign out_opcode = head_e.opcode;
  assign out_y      = head_e.y;
  assign out_flags  = {head_e.n, head_e.z, head_e.c, head_e.v};

  // Occupancy and head pointer; 1-bit hd wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      hd    <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (pop) hd <= ~hd;
    end
  end

  // Entry storage; written only at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two slots are reset even though they are storage, because
      // out_* must read back as zero after reset while the buffer is empty.
      slot[0] <= '0;
      slot[1] <= '0;
    end else if (push) begin
      slot[tail] <= in_e;
    end
  end

  // Architectural flags, carry feedback and sticky overflow track every push,
  // independent of consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= 4'd0;
      carry_fb   <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      if (push) begin
        flags_q  <= {in_negative, in_zero, in_cout, in_overflow};
        carry_fb <= in_cout;
      end
      sticky_ovf <= (sticky_clr ? 1'b0 : sticky_ovf) | (push & in_overflow);
    end
  end

`ifdef ALU_RESULT_STAGE_PERF_EN
  // Performance counters: completed transfers and consumer-stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt  <= 16'd0;
      stall_cnt <= 16'd0;
    end else if (sticky_clr) begin
      xfer_cnt  <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (pop) xfer_cnt <= xfer_cnt + 16'd1;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed-vector bench with a scoreboard. Stimulus
// pushes the expected entry into a queue on each accepted push; a separate
// monitor pops and compares on every consumer handshake.
module tb_alu_result_stage;

  localparam int         N           = 4;
  localparam logic [3:0] LL_SHIFT_OP = 4'b0101;
  localparam logic [3:0] ADD_OP      = 4'b0000;

  typedef struct packed {
    logic [3:0]   opcode;
    logic [N-1:0] y;
    logic [3:0]   flags;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_opcode;
  logic [N-1:0] in_y;
  logic         in_cout, in_overflow, in_negative, in_zero;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_opcode;
  logic [N-1:0] out_y;
  logic [3:0]   out_flags;
  logic [3:0]   flags_q;
  logic         carry_fb;
  logic         sticky_ovf;
  logic         sticky_clr;
`ifdef ALU_RESULT_STAGE_PERF_EN
  logic [15:0]  xfer_cnt;
  logic [15:0]  stall_cnt;
`endif

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_result_stage #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_y       (in_y),
    .in_cout    (in_cout),
    .in_overflow(in_overflow),
    .in_negative(in_negative),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_y      (out_y),
    .out_flags  (out_flags),
    .flags_q    (flags_q),
    .carry_fb   (carry_fb),
    .sticky_ovf (sticky_ovf),
    .sticky_clr (sticky_clr)
`ifdef ALU_RESULT_STAGE_PERF_EN
    ,
    .xfer_cnt   (xfer_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a handshake seen at the falling edge completes on the
  // next rising edge, so the head entry is compared here.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_y), 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("sb_opcode", 32'(out_opcode), 32'(e.opcode));
        check("sb_y",      32'(out_y),      32'(e.y));
        check("sb_flags",  32'(out_flags),  32'(e.flags));
      end
    end
  end

  // Called just after a rising edge; holds the vector until accepted.
  task automatic push_op(input logic [3:0] op, input logic [N-1:0] y,
                         input logic n, input logic z, input logic c,
                         input logic v);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_y        = y;
    in_negative = n;
    in_zero     = z;
    in_cout     = c;
    in_overflow = v;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{opcode: op, y: y, flags: {n, z, c, v}});
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("push_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_y = '0;
    in_cout = 1'b0; in_overflow = 1'b0; in_negative = 1'b0; in_zero = 1'b0;
    out_ready = 1'b1; sticky_clr = 1'b0;

    // 1. Reset / idle
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_flags_q",    32'(flags_q),    32'd0);
    check("rst_carry_fb",   32'(carry_fb),   32'd0);
    check("rst_sticky",     32'(sticky_ovf), 32'd0);
    check("rst_out_y",      32'(out_y),      32'd0);
    check("rst_out_opcode", 32'(out_opcode), 32'd0);
    check("rst_out_flags",  32'(out_flags),  32'd0);

    // 2. Single pass: visible right after the accepting edge, gone one later
    push_op(LL_SHIFT_OP, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    check("single_valid",  32'(out_valid),  32'd1);
    check("single_y",      32'(out_y),      32'd2);
    check("single_opcode", 32'(out_opcode), 32'(LL_SHIFT_OP));
    idle(1);
    check("single_drained",   32'(out_valid), 32'd0);
    check("single_hold_last", 32'(out_y),     32'd2);

    // 3. Backpressure: third push stalls until the consumer releases
    out_ready = 1'b0;
    push_op(ADD_OP, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_op(ADD_OP, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_full_in_ready", 32'(in_ready),  32'd0);
    check("bp_full_valid",    32'(out_valid), 32'd1);
    check("bp_head_y",        32'(out_y),     32'd1);
    idle(2);
    check("bp_head_stable",   32'(out_y),     32'd1);
    fork
      push_op(ADD_OP, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      begin idle(3); out_ready = 1'b1; end
    join
    idle(4);
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4. Streaming: one push per cycle, buffer never exceeds one entry
    for (int i = 0; i < 16; i++) begin
      push_op(ADD_OP, 4'(i), 1'(i[3]), 1'(i == 0), 1'b0, 1'b0);
      check("stream_in_ready", 32'(in_ready),  32'd1);
      check("stream_valid",    32'(out_valid), 32'd1);
      check("stream_y",        32'(out_y),     32'(i));
    end
    idle(1);
    check("stream_drained", 32'(out_valid), 32'd0);

    // 5. Carry feedback and sticky overflow
    push_op(ADD_OP, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    check("cs_carry_fb", 32'(carry_fb),   32'd1);
    check("cs_flags_q",  32'(flags_q),    32'b0011);
    check("cs_sticky",   32'(sticky_ovf), 32'd1);
    sticky_clr = 1'b1;
    push_op(ADD_OP, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    sticky_clr = 1'b0;
    check("cs_clr_sticky",  32'(sticky_ovf), 32'd0);
    check("cs_clr_carry",   32'(carry_fb),   32'd0);
    check("cs_clr_flags_q", 32'(flags_q),    32'b0100);
    sticky_clr = 1'b1;
    push_op(ADD_OP, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    sticky_clr = 1'b0;
    check("cs_clr_and_ovf", 32'(sticky_ovf), 32'd1);
    idle(2);
    check("cs_sb_empty", 32'(exp_q.size()), 32'd0);

    // 6. Asynchronous reset while full and stalled
    out_ready = 1'b0;
    push_op(ADD_OP, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    push_op(ADD_OP, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ar_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid_now",    32'(out_valid),  32'd0);
    check("ar_in_ready_now", 32'(in_ready),   32'd1);
    check("ar_out_y_now",    32'(out_y),      32'd0);
    check("ar_sticky_now",   32'(sticky_ovf), 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("ar_no_stale", 32'(out_valid), 32'd0);
    end
    check("ar_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
